// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin arbiter sharing one valid/ready sink between N_REQ producers.
// Define ARB_FIXED_PRIO_EN to pin the search start at requester 0 (fixed priority).
module rr_stream_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DWIDTH    = 32,
    parameter int BURST_LEN = 8,
    parameter int IDW       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        s_valid,
    output logic [N_REQ-1:0]        s_ready,
    input  logic [N_REQ*DWIDTH-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DWIDTH-1:0]       m_data,
    output logic [IDW-1:0]          m_id,
    output logic                    m_last,
    output logic                    busy
);
    localparam int CW   = $clog2(BURST_LEN) + 1;
    localparam int NPAD = 1 << IDW;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    prio_ptr_q, prio_ptr_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NPAD-1:0]   valid_pad;
    logic [NPAD-1:0]   ready_pad;
    logic [DWIDTH-1:0] data_arr [NPAD];
    logic              found;
    logic [IDW-1:0]    pick;
    int                search_idx;
    logic [IDW-1:0]    search_sel;
    logic              hs;
    logic              at_last;

    // Pad requesters up to 2**IDW so any id value indexes safely; padded slots never request.
    for (genvar g = 0; g < NPAD; g++) begin : g_pad
        if (g < N_REQ) begin : g_real
            assign data_arr[g]  = s_data[g*DWIDTH +: DWIDTH];
            assign valid_pad[g] = s_valid[g];
        end else begin : g_none
            assign data_arr[g]  = '0;
            assign valid_pad[g] = 1'b0;
        end
    end

    always_comb begin
        found      = 1'b0;
        pick       = '0;
        search_idx = 0;
        search_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            search_idx = (int'(prio_ptr_q) + k) % N_REQ;
            search_sel = IDW'(search_idx);
            if (!found && valid_pad[search_sel]) begin
                found = 1'b1;
                pick  = search_sel;
            end
        end
    end

    assign at_last = (beat_cnt_q == LAST_CNT);
    assign m_data  = data_arr[grant_q];
    assign m_id    = grant_q;
    assign busy    = (state_q == S_RUN);
    assign s_ready = ready_pad[N_REQ-1:0];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_ptr_d = prio_ptr_q;
        beat_cnt_d = beat_cnt_q;
        ready_pad  = '0;
        m_valid    = 1'b0;
        if (state_q == S_RUN) begin
            m_valid            = valid_pad[grant_q];
            ready_pad[grant_q] = m_ready;
        end
        hs     = m_valid & m_ready;
        m_last = m_valid & at_last;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // A fresh grant is held until one beat moves; afterwards a pause releases it.
                if ((hs && at_last) || (!valid_pad[grant_q] && (beat_cnt_q != '0))) begin
                    state_d    = S_IDLE;
                    beat_cnt_d = '0;
`ifdef ARB_FIXED_PRIO_EN
                    prio_ptr_d = '0;
`else
                    prio_ptr_d = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
                end else if (hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            prio_ptr_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_ptr_q <= prio_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule
